// File: rtl/systolic_row_loader.sv
// Ping-pong operand loader: fills one N*N bank from a valid/ready stream while the
// consumer reads the other bank through N combinational read ports.
module systolic_row_loader #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  localparam int DEPTH     = N * N,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [DATA_WIDTH-1:0]          s_data_i,
  input  logic                           s_valid_i,
  input  logic                           s_last_i,
  output logic                           s_ready_o,
  output logic                           start_o,
  input  logic                           drain_done_i,
  input  logic [N-1:0][AW-1:0]           rd_addr_i,
  output logic [N-1:0][DATA_WIDTH-1:0]   rd_data_o,
  output logic [15:0]                    frames_o,
  output logic                           err_o
);

  // state     | meaning
  // B_EMPTY   | bank holds no data, may be written
  // B_FILLING | bank partially written
  // B_FULL    | frame complete, waiting for consumer
  // B_DRAINING| consumer is reading this bank
  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_st_e;

  bank_st_e        bank_q [2];
  bank_st_e        bank_d [2];
  logic            wb_q, wb_d;
  logic            rb_q, rb_d;
  logic [AW-1:0]   widx_q, widx_d;
  logic            pad_q, pad_d;
  logic            done_q, done_d;
  logic [15:0]     frames_q, frames_d;
  logic            err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  logic                  accept;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  last_word;
  logic                  done_rise;
  logic                  draining_any;

  assign s_ready_o = ~pad_q & ((bank_q[wb_q] == B_EMPTY) | (bank_q[wb_q] == B_FILLING));
  assign frames_o  = frames_q;
  assign err_o     = err_q;

  always_comb begin
    bank_d       = bank_q;
    wb_d         = wb_q;
    rb_d         = rb_q;
    widx_d       = widx_q;
    pad_d        = pad_q;
    frames_d     = frames_q;
    err_d        = err_q;
    done_d       = drain_done_i;
    accept       = s_valid_i & s_ready_o;
    wr_en        = accept | pad_q;
    wr_data      = pad_q ? '0 : s_data_i;
    last_word    = (widx_q == AW'(DEPTH - 1));
    done_rise    = drain_done_i & ~done_q;
    draining_any = (bank_q[0] == B_DRAINING) | (bank_q[1] == B_DRAINING);
    start_o      = (bank_q[rb_q] == B_FULL) & ~draining_any;

    if (wr_en) begin
      if (bank_q[wb_q] == B_EMPTY) bank_d[wb_q] = B_FILLING;
      // Early last: flag it and zero-fill the remainder of the bank ourselves.
      if (accept && s_last_i && !last_word) begin
        err_d = 1'b1;
        pad_d = 1'b1;
      end
      if (accept && !s_last_i && last_word) err_d = 1'b1;
      if (last_word) begin
        bank_d[wb_q] = B_FULL;
        wb_d         = ~wb_q;
        widx_d       = '0;
        pad_d        = 1'b0;
        frames_d     = frames_q + 16'd1;
      end else begin
        widx_d = widx_q + AW'(1);
      end
    end

    // Done only ever targets the draining bank, never the bank being written.
    if (done_rise && bank_q[rb_q] == B_DRAINING) begin
      bank_d[rb_q] = B_EMPTY;
      rb_d         = ~rb_q;
    end

    if (start_o) bank_d[rb_q] = B_DRAINING;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bank_q[0] <= B_EMPTY;
      bank_q[1] <= B_EMPTY;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      widx_q    <= '0;
      pad_q     <= 1'b0;
      done_q    <= 1'b0;
      frames_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      widx_q    <= widx_d;
      pad_q     <= pad_d;
      done_q    <= done_d;
      frames_q  <= frames_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wb_q][widx_q] <= wr_data;
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      rd_data_o[k] = mem_q[rb_q][rd_addr_i[k]];
    end
  end

endmodule

// File: tb/tb_systolic_row_loader.sv
// Scoreboard bench for systolic_row_loader at N=4: stimulus queues expected frames,
// a monitor checks frame contents and counters on every start pulse.
module tb_systolic_row_loader;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 4;

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic [DW-1:0]      s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready_o;
  logic               start_o;
  logic               drain_done;
  logic [N-1:0][AW-1:0] rd_addr;
  logic [N-1:0][DW-1:0] rd_data;
  logic [15:0]        frames_o;
  logic               err_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0][31:0] data;
    logic [15:0]       frames;
    logic              err;
  } exp_t;

  exp_t sb[$];

  systolic_row_loader #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_last_i     (s_last),
    .s_ready_o    (s_ready_o),
    .start_o      (start_o),
    .drain_done_i (drain_done),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .frames_o     (frames_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int base, input int lastidx, input int fr, input logic e);
    exp_t x;
    for (int i = 0; i < 16; i++) x.data[i] = (i <= lastidx) ? 32'(base + i) : 32'd0;
    x.frames = 16'(fr);
    x.err    = e;
    return x;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    logic rdy;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    do begin
      rdy = s_ready_o;
      @(posedge clk_i); #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %0h never accepted, ready=%0b required 1", d, s_ready_o);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < 16; i++) send(32'(base + i), i == 15);
  endtask

  // Monitor: each start pulse must match the oldest queued frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (start_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: start_o=1 with no frame queued, required 0");
        end else begin
          e = sb.pop_front();
          chk("start_frames", 32'(frames_o), 32'(e.frames));
          chk("start_err", 32'(err_o), 32'(e.err));
          for (int j = 0; j < N; j++) begin
            for (int k = 0; k < N; k++) rd_addr[k] = AW'(N * k + j);
            #1;
            for (int k = 0; k < N; k++) chk("rd_data", rd_data[k], e.data[N * k + j]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rstn_i = 1'b0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    drain_done = 1'b0;
    rd_addr = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(s_ready_o), 32'd1);
    chk("rst_start", 32'(start_o), 32'd0);
    chk("rst_frames", 32'(frames_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    @(negedge clk_i); rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Frame A: basic load, start latency of one cycle.
    sb.push_back(mk(0, 15, 1, 1'b0));
    send_frame(0);
    chk("a_start_next", 32'(start_o), 32'd1);
    chk("a_frames", 32'(frames_o), 32'd1);
    @(posedge clk_i); #1;
    chk("a_start_once", 32'(start_o), 32'd0);
    drain_done = 1'b1;
    @(posedge clk_i); #1;
    drain_done = 1'b0;
    @(posedge clk_i); #1;

    // Frames B and C back-to-back, no drain: backpressure after word 32.
    sb.push_back(mk(16, 15, 2, 1'b0));
    sb.push_back(mk(32, 15, 3, 1'b0));
    send_frame(16);
    send_frame(32);
    chk("bp_ready", 32'(s_ready_o), 32'd0);
    chk("bp_frames", 32'(frames_o), 32'd3);
    s_data = 32'd48; s_valid = 1'b1; s_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      chk("bp_stall", 32'(s_ready_o), 32'd0);
    end
    chk("bp_no_accept", 32'(frames_o), 32'd3);
    drain_done = 1'b1;
    @(posedge clk_i); #1;
    chk("c_start", 32'(start_o), 32'd1);
    chk("c_ready", 32'(s_ready_o), 32'd1);
    drain_done = 1'b0;

    // Frame D: last on word 5 -> pad of 10 zero words, err sticky.
    sb.push_back(mk(48, 5, 4, 1'b1));
    send(32'd48, 1'b0);
    send(32'd49, 1'b0);
    send(32'd50, 1'b0);
    send(32'd51, 1'b0);
    drain_done = 1'b1;
    send(32'd52, 1'b0);
    send(32'd53, 1'b1);
    chk("d_err", 32'(err_o), 32'd1);
    cnt = 0;
    while (!s_ready_o && cnt < 40) begin
      cnt++;
      @(posedge clk_i); #1;
    end
    chk("d_pad_cycles", 32'(cnt), 32'd10);
    chk("d_frames", 32'(frames_o), 32'd4);
    drain_done = 1'b0;
    @(posedge clk_i); #1;

    // Frame E: drain of D coincides with E's final word.
    sb.push_back(mk(64, 15, 5, 1'b1));
    for (int i = 0; i < 15; i++) send(32'(64 + i), 1'b0);
    drain_done = 1'b1;
    send(32'd79, 1'b1);
    chk("e_start_next", 32'(start_o), 32'd1);
    @(posedge clk_i); #1;
    chk("e_start_once", 32'(start_o), 32'd0);
    drain_done = 1'b0;

    // Reset mid-frame at widx=7, then a clean frame.
    for (int i = 0; i < 7; i++) send(32'(200 + i), 1'b0);
    rstn_i = 1'b0;
    #2;
    chk("mid_rst_ready", 32'(s_ready_o), 32'd1);
    chk("mid_rst_frames", 32'(frames_o), 32'd0);
    chk("mid_rst_err", 32'(err_o), 32'd0);
    chk("mid_rst_start", 32'(start_o), 32'd0);
    @(negedge clk_i); rstn_i = 1'b1;
    @(posedge clk_i); #1;
    chk("post_rst_start", 32'(start_o), 32'd0);
    sb.push_back(mk(100, 15, 1, 1'b0));
    send_frame(100);
    chk("g_start", 32'(start_o), 32'd1);
    repeat (5) @(posedge clk_i);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
